task_msg_parser: RTL and testbench
==================================

// Module: task_msg_parser
//
// PURPOSE
//  Streaming receiver for task ICD messages: accepts 32-bit words on a valid/ready stream
//  and assembles the 4-word header (LEN, SEQ_ID, TASK_ID, STATUS) and the payload.
//  Validates each message and emits one parsed record per message with a status_t verdict.
//  Sits between the link deframer and the task dispatcher (BANK/OUT handlers).
//
// PARAMETERS
//  MAX_MSG_WORDS  12   largest legal message in words, header included (>= HEADER_WORDS)
//  TASK_ID_LO     100  lowest legal TASK_ID
//  NUM_TASK_IDS   2    legal TASK_IDs are TASK_ID_LO .. TASK_ID_LO+NUM_TASK_IDS-1
//
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     reset, asynchronous assert, active-low
//  s_valid          in   1     input word valid
//  s_ready          out  1     parser can accept a word
//  s_data           in   32    input word, header first
//  s_last           in   1     final word of message
//  m_valid          out  1     parsed record valid
//  m_ready          in   1     dispatcher accepts record
//  m_len            out  32    received LEN field, in bytes
//  m_seq_id         out  32    received SEQ_ID
//  m_task_id        out  32    received TASK_ID
//  m_status         out  32    status_t verdict
//  m_payload        out  (MAX_MSG_WORDS-4)*32  payload; word k at [k*32 +: 32]
//  m_payload_words  out  $clog2(MAX_MSG_WORDS-3)  payload words stored
//
// BEHAVIOUR
//  - Reset: all m_* outputs are 0, s_ready=0, state=HDR, word count=0. s_ready=1 on the first clk after rst_n deasserts.
//  - Reset mid-message discards the partial message. No record is emitted for it.
//  - FSM states:
//    - HDR: s_ready=1; store words 0..3.
//    - PAYLOAD: s_ready=1; store word at payload index wcnt-4.
//    - DRAIN: s_ready=1; discard words until s_last.
//    - EMIT: s_ready=0, m_valid=1.
//  - A word transfers when s_valid && s_ready.
//  - Header checks are made on the transfer of word 3. Any failure gives HEADER_INVALID:
//    - LEN[1:0]!=0
//    - LEN<16
//    - LEN>MAX_MSG_WORDS*4
//    - TASK_ID outside the legal range
//    - STATUS word != TASK_VALID
//  - s_last on header word 0..2 -> EMIT, HEADER_INVALID.
//  - Failed header -> EMIT if s_last, else DRAIN. Verdict is HEADER_INVALID in both cases.
//  - Good header, LEN==16: s_last -> EMIT TASK_VALID; no s_last -> DRAIN, PAYLOAD_INVALID.
//  - Good header, LEN>16 -> PAYLOAD. Let n = wcnt+1 after the current transfer:
//    - s_last && n==LEN/4 -> TASK_VALID.
//    - s_last && n<LEN/4 -> PAYLOAD_INVALID (short message).
//    - n==LEN/4 && !s_last -> DRAIN, PAYLOAD_INVALID (long message).
//  - DRAIN keeps the verdict it entered with and goes to EMIT on s_last.
//  - Latency: m_valid rises on the cycle after the s_last transfer.
//  - EMIT holds all m_* stable until m_valid && m_ready. On that cycle:
//    - m_valid drops next cycle;
//    - state returns to HDR; s_ready=1 next cycle;
//    - payload store and word count are cleared.
//  - Payload words not received read as 0.
//  - m_payload_words = number of payload words stored, never more than MAX_MSG_WORDS-4.
//  - EMIT never executes EXE_ERROR; that value is reserved for downstream.
//
// CONFIGURATION
//  TASK_MSG_PARSER_SEQ_CHECK_EN
//  - Defined: sequence-ID continuity check.
//    - The first TASK_VALID message after reset sets the baseline.
//    - Every later message must carry SEQ_ID == last TASK_VALID SEQ_ID + 1, mod 2^32; else HEADER_INVALID.
//    - The expected value advances only on a TASK_VALID handshake.
//  - Undefined: SEQ_ID is passed through unchecked; no sequence state is built.
//
// STRUCTURE
//  task_icd_pkg gains:
//  - typedef msg_hdr_t, a packed struct {len, seq_id, task_id, status}
//  - typedef parser_state_t, the enum {HDR, PAYLOAD, DRAIN, EMIT}
//  Existing package constants reused: HEADER_WORDS, the *_IDX constants, status_t.
//  Sub-module task_hdr_check (combinational): msg_hdr_t + parameters -> header_ok, len_words.
//
// TESTING
//  1. LEN=24, SEQ=5, TASK=100, STATUS=0, payload AA,BB, last on word 5 -> TASK_VALID, payload_words=2, m_payload[63:0]=BB_AA.
//  2. TASK=102 (NUM_TASK_IDS=2), LEN=20, 5 words -> HEADER_INVALID after word 4 with s_last; no early emit.
//  3. LEN=28 with s_last on word 5 (short) -> PAYLOAD_INVALID, payload_words=2. LEN=20 with 7 words (long) -> DRAIN, PAYLOAD_INVALID.
//  4. Hold m_ready=0 for 10 cycles after a valid record -> s_ready=0 and m_* stable; m_ready=1 -> s_ready=1 next cycle.
//  5. Assert rst_n=0 after word 2 of a message -> no record; the next clean message parses TASK_VALID.
//  6. With SEQ_CHECK_EN: SEQ 7,8,10 -> TASK_VALID, TASK_VALID, HEADER_INVALID. Then SEQ=9 -> TASK_VALID. Also 0xFFFFFFFF then 0 -> both TASK_VALID.

Source files
------------

// File: rtl/task_icd_pkg.sv
// rtl/task_icd_pkg.sv - task ICD message types and constants shared by the parser
package task_icd_pkg;

  localparam int HEADER_WORDS = 4;
  localparam int LEN_IDX      = 0;
  localparam int SEQ_ID_IDX   = 1;
  localparam int TASK_ID_IDX  = 2;
  localparam int STATUS_IDX   = 3;

  typedef enum logic [31:0] {
    TASK_VALID      = 32'd0,
    HEADER_INVALID  = 32'd1,
    PAYLOAD_INVALID = 32'd2,
    EXE_ERROR       = 32'd3
  } status_t;

  typedef struct packed {
    logic [31:0] len;
    logic [31:0] seq_id;
    logic [31:0] task_id;
    logic [31:0] status;
  } msg_hdr_t;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DRAIN,
    EMIT
  } parser_state_t;

endpackage

// File: rtl/task_msg_parser_hdr_check.sv
// rtl/task_msg_parser_hdr_check.sv - combinational header validation (task_hdr_check)
module task_hdr_check
  import task_icd_pkg::*;
#(
  parameter int MAX_MSG_WORDS = 12,
  parameter int TASK_ID_LO    = 100,
  parameter int NUM_TASK_IDS  = 2,
  localparam int WC_W         = $clog2(MAX_MSG_WORDS + 1)
) (
  input  msg_hdr_t          hdr,
  input  logic              seq_check,
  input  logic [31:0]       seq_exp,
  output logic              header_ok,
  output logic [WC_W-1:0]   len_words
);

  logic len_ok;
  logic task_ok;
  logic status_ok;
  logic seq_ok;

  always_comb begin
    len_ok    = (hdr.len[1:0] == 2'b00) && (hdr.len >= 32'd16) &&
                (hdr.len <= 32'(MAX_MSG_WORDS * 4));
    task_ok   = (hdr.task_id >= 32'(TASK_ID_LO)) &&
                (hdr.task_id < 32'(TASK_ID_LO + NUM_TASK_IDS));
    status_ok = (hdr.status == TASK_VALID);
    seq_ok    = !seq_check || (hdr.seq_id == seq_exp);
    header_ok = len_ok && task_ok && status_ok && seq_ok;
    // Only meaningful when len_ok; the range check bounds LEN/4 to WC_W bits.
    len_words = hdr.len[WC_W+1:2];
  end

endmodule

// File: rtl/task_msg_parser.sv
// rtl/task_msg_parser.sv - task ICD stream parser; option TASK_MSG_PARSER_SEQ_CHECK_EN
module task_msg_parser
  import task_icd_pkg::*;
#(
  parameter int MAX_MSG_WORDS = 12,
  parameter int TASK_ID_LO    = 100,
  parameter int NUM_TASK_IDS  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [31:0]                           s_data,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [31:0]                           m_len,
  output logic [31:0]                           m_seq_id,
  output logic [31:0]                           m_task_id,
  output logic [31:0]                           m_status,
  output logic [(MAX_MSG_WORDS-4)*32-1:0]       m_payload,
  output logic [$clog2(MAX_MSG_WORDS-3)-1:0]    m_payload_words
);

  localparam int P_WORDS = MAX_MSG_WORDS - HEADER_WORDS;
  localparam int PW_W    = $clog2(MAX_MSG_WORDS - 3);
  localparam int WC_W    = $clog2(MAX_MSG_WORDS + 1);

  parser_state_t            state_q, state_d;
  status_t                  verdict_q, verdict_d;
  logic                     ready_q;
  logic [WC_W-1:0]          wcnt_q;
  logic [WC_W-1:0]          lw_q;
  logic [WC_W-1:0]          n_next;
  logic [WC_W-1:0]          pidx;
  logic [PW_W-1:0]          pw_q;
  logic [31:0]              len_q, seq_q, task_q;
  logic [P_WORDS*32-1:0]    payload_q;
  msg_hdr_t                 hdr_cand;
  logic                     hdr_ok;
  logic [WC_W-1:0]          len_words;
  logic                     seq_check;
  logic [31:0]              seq_exp;
  logic                     xfer;
  logic                     done;
  logic                     last_hdr;

  assign xfer     = s_valid && s_ready;
  assign done     = m_valid && m_ready;
  assign last_hdr = (wcnt_q == WC_W'(STATUS_IDX));
  assign n_next   = wcnt_q + WC_W'(1);
  assign pidx     = wcnt_q - WC_W'(HEADER_WORDS);
  assign hdr_cand = '{len: len_q, seq_id: seq_q, task_id: task_q, status: s_data};

  task_hdr_check #(
    .MAX_MSG_WORDS (MAX_MSG_WORDS),
    .TASK_ID_LO    (TASK_ID_LO),
    .NUM_TASK_IDS  (NUM_TASK_IDS)
  ) u_hdr_check (
    .hdr       (hdr_cand),
    .seq_check (seq_check),
    .seq_exp   (seq_exp),
    .header_ok (hdr_ok),
    .len_words (len_words)
  );

`ifdef TASK_MSG_PARSER_SEQ_CHECK_EN
  logic        seq_base_q;
  logic [31:0] seq_exp_q;

  // Baseline is taken from the first accepted TASK_VALID record after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_base_q <= 1'b0;
      seq_exp_q  <= '0;
    end else if (done && verdict_q == TASK_VALID) begin
      seq_base_q <= 1'b1;
      seq_exp_q  <= seq_q + 32'd1;
    end
  end

  assign seq_check = seq_base_q;
  assign seq_exp   = seq_exp_q;
`else
  assign seq_check = 1'b0;
  assign seq_exp   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != EMIT);
    end
  end

  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    m_valid   = 1'b0;
    case (state_q)
      HDR: begin
        if (xfer) begin
          if (!last_hdr) begin
            if (s_last) begin
              state_d   = EMIT;
              verdict_d = HEADER_INVALID;
            end
          end else if (!hdr_ok) begin
            state_d   = s_last ? EMIT : DRAIN;
            verdict_d = HEADER_INVALID;
          end else if (len_words == WC_W'(HEADER_WORDS)) begin
            state_d   = s_last ? EMIT : DRAIN;
            verdict_d = s_last ? TASK_VALID : PAYLOAD_INVALID;
          end else if (s_last) begin
            state_d   = EMIT;
            verdict_d = PAYLOAD_INVALID;
          end else begin
            state_d   = PAYLOAD;
            verdict_d = TASK_VALID;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (s_last) begin
            state_d   = EMIT;
            verdict_d = (n_next == lw_q) ? TASK_VALID : PAYLOAD_INVALID;
          end else if (n_next == lw_q) begin
            state_d   = DRAIN;
            verdict_d = PAYLOAD_INVALID;
          end
        end
      end
      DRAIN: begin
        if (xfer && s_last) state_d = EMIT;
      end
      EMIT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verdict_q <= TASK_VALID;
      wcnt_q    <= '0;
      lw_q      <= '0;
      pw_q      <= '0;
      len_q     <= '0;
      seq_q     <= '0;
      task_q    <= '0;
      payload_q <= '0;
    end else if (done) begin
      verdict_q <= TASK_VALID;
      wcnt_q    <= '0;
      lw_q      <= '0;
      pw_q      <= '0;
      len_q     <= '0;
      seq_q     <= '0;
      task_q    <= '0;
      payload_q <= '0;
    end else begin
      verdict_q <= verdict_d;
      if (xfer && state_q == HDR) begin
        wcnt_q <= n_next;
        if (wcnt_q == WC_W'(LEN_IDX))     len_q  <= s_data;
        if (wcnt_q == WC_W'(SEQ_ID_IDX))  seq_q  <= s_data;
        if (wcnt_q == WC_W'(TASK_ID_IDX)) task_q <= s_data;
        if (last_hdr)                     lw_q   <= len_words;
      end else if (xfer && state_q == PAYLOAD) begin
        // Exit on n == LEN/4 keeps pidx below P_WORDS.
        wcnt_q                   <= n_next;
        payload_q[pidx*32 +: 32] <= s_data;
        pw_q                     <= pw_q + PW_W'(1);
      end
    end
  end

  assign s_ready         = ready_q;
  assign m_len           = len_q;
  assign m_seq_id        = seq_q;
  assign m_task_id       = task_q;
  assign m_status        = verdict_q;
  assign m_payload       = payload_q;
  assign m_payload_words = pw_q;

endmodule

// File: tb/tb_task_msg_parser.sv
// tb/tb_task_msg_parser.sv - directed self-checking bench for task_msg_parser
module tb_task_msg_parser;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_len, m_seq_id, m_task_id, m_status;
  logic [255:0] m_payload;
  logic [3:0]   m_payload_words;

  int total = 0;
  int bad   = 0;
  logic [31:0] msg [16];

  localparam logic [31:0] ST_OK  = 32'd0;
  localparam logic [31:0] ST_HDR = 32'd1;
  localparam logic [31:0] ST_PAY = 32'd2;

  task_msg_parser dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_last          (s_last),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_len           (m_len),
    .m_seq_id        (m_seq_id),
    .m_task_id       (m_task_id),
    .m_status        (m_status),
    .m_payload       (m_payload),
    .m_payload_words (m_payload_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int t;
    @(negedge clk);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("s_ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_word(msg[i], i == n - 1);
  endtask

  task automatic hdr(input logic [31:0] len, input logic [31:0] seq,
                     input logic [31:0] tid, input logic [31:0] st);
    msg[0] = len; msg[1] = seq; msg[2] = tid; msg[3] = st;
  endtask

  task automatic expect_rec(input string tag, input logic [31:0] st, input logic [3:0] pw);
    int t;
    t = 0;
    @(negedge clk);
    while (!m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd1);
    chk({tag, "_status"}, 64'(m_status), 64'(st));
    chk({tag, "_pw"}, 64'(m_payload_words), 64'(pw));
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk({tag, "_drop_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(s_ready), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_len", 64'(m_len), 64'd0);
    chk("rst_m_status", 64'(m_status), 64'd0);
    chk("rst_m_pw", 64'(m_payload_words), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready_before_clk", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_ready_after_clk", 64'(s_ready), 64'd1);

    // 1: good message with two payload words; record visible right after s_last
    hdr(32'd24, 32'd5, 32'd100, 32'd0);
    msg[4] = 32'hAA; msg[5] = 32'hBB;
    send_msg(6);
    chk("t1_latency", 64'(m_valid), 64'd1);
    expect_rec("t1", ST_OK, 4'd2);
    chk("t1_len", 64'(m_len), 64'd24);
    chk("t1_seq", 64'(m_seq_id), 64'd5);
    chk("t1_task", 64'(m_task_id), 64'd100);
    chk("t1_payload_lo", m_payload[63:0], 64'h0000_00BB_0000_00AA);
    chk("t1_payload_hi", m_payload[127:64], 64'd0);
    accept("t1");

    // 2: TASK_ID out of range, no record before s_last
    hdr(32'd20, 32'd6, 32'd102, 32'd0);
    msg[4] = 32'hCC;
    for (int i = 0; i < 4; i++) send_word(msg[i], 1'b0);
    chk("t2_no_early", 64'(m_valid), 64'd0);
    send_word(msg[4], 1'b1);
    expect_rec("t2", ST_HDR, 4'd0);
    accept("t2");

    // 3a: short message
    hdr(32'd28, 32'd6, 32'd101, 32'd0);
    msg[4] = 32'h11; msg[5] = 32'h22;
    send_msg(6);
    expect_rec("t3a", ST_PAY, 4'd2);
    accept("t3a");

    // 3b: long message, extra words drained
    hdr(32'd20, 32'd6, 32'd100, 32'd0);
    msg[4] = 32'h33; msg[5] = 32'h44; msg[6] = 32'h55;
    send_msg(7);
    expect_rec("t3b", ST_PAY, 4'd1);
    chk("t3b_payload", m_payload[63:0], 64'h0000_0000_0000_0033);
    accept("t3b");

    // Header boundaries
    hdr(32'd18, 32'd6, 32'd100, 32'd0);
    send_msg(4);
    expect_rec("len_unaligned", ST_HDR, 4'd0);
    accept("len_unaligned");
    hdr(32'd12, 32'd6, 32'd100, 32'd0);
    send_msg(4);
    expect_rec("len_short", ST_HDR, 4'd0);
    accept("len_short");
    hdr(32'd52, 32'd6, 32'd100, 32'd0);
    send_msg(4);
    expect_rec("len_big", ST_HDR, 4'd0);
    accept("len_big");
    hdr(32'd99, 32'd6, 32'd99, 32'd0);
    msg[0] = 32'd16;
    send_msg(4);
    expect_rec("task_low", ST_HDR, 4'd0);
    accept("task_low");
    hdr(32'd16, 32'd6, 32'd100, 32'd2);
    send_msg(4);
    expect_rec("status_bad", ST_HDR, 4'd0);
    accept("status_bad");
    hdr(32'd16, 32'd6, 32'd100, 32'd0);
    send_msg(2);
    expect_rec("last_in_hdr", ST_HDR, 4'd0);
    accept("last_in_hdr");
    hdr(32'd16, 32'd6, 32'd100, 32'd0);
    msg[4] = 32'h66;
    send_msg(5);
    expect_rec("len16_long", ST_PAY, 4'd0);
    accept("len16_long");

    // Largest legal message fills every payload slot
    hdr(32'd48, 32'd6, 32'd101, 32'd0);
    for (int i = 0; i < 8; i++) msg[4 + i] = 32'h100 + 32'(i);
    send_msg(12);
    expect_rec("max_len", ST_OK, 4'd8);
    chk("max_len_top", m_payload[255:192], 64'h0000_0107_0000_0106);
    accept("max_len");

    // 4: backpressure on the record
    hdr(32'd16, 32'd7, 32'd100, 32'd0);
    send_msg(4);
    expect_rec("t4", ST_OK, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 64'(s_ready), 64'd0);
      chk("t4_hold_valid", 64'(m_valid), 64'd1);
      chk("t4_hold_seq", 64'(m_seq_id), 64'd7);
    end
    accept("t4");

    // 5: reset in the middle of a message
    hdr(32'd24, 32'd8, 32'd100, 32'd0);
    for (int i = 0; i < 3; i++) send_word(msg[i], 1'b0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("t5_no_record", 64'(m_valid), 64'd0);
    hdr(32'd20, 32'd10, 32'd101, 32'd0);
    msg[4] = 32'h77;
    send_msg(5);
    expect_rec("t5", ST_OK, 4'd1);
    chk("t5_seq", 64'(m_seq_id), 64'd10);
    accept("t5");

`ifdef TASK_MSG_PARSER_SEQ_CHECK_EN
    // 6: sequence continuity
    do_reset();
    hdr(32'd16, 32'd7, 32'd100, 32'd0);  send_msg(4);
    expect_rec("seq7", ST_OK, 4'd0);     accept("seq7");
    hdr(32'd16, 32'd8, 32'd100, 32'd0);  send_msg(4);
    expect_rec("seq8", ST_OK, 4'd0);     accept("seq8");
    hdr(32'd16, 32'd10, 32'd100, 32'd0); send_msg(4);
    expect_rec("seq10", ST_HDR, 4'd0);   accept("seq10");
    hdr(32'd16, 32'd9, 32'd100, 32'd0);  send_msg(4);
    expect_rec("seq9", ST_OK, 4'd0);     accept("seq9");
    do_reset();
    hdr(32'd16, 32'hFFFF_FFFF, 32'd100, 32'd0); send_msg(4);
    expect_rec("seq_max", ST_OK, 4'd0);  accept("seq_max");
    hdr(32'd16, 32'd0, 32'd100, 32'd0);  send_msg(4);
    expect_rec("seq_wrap", ST_OK, 4'd0); accept("seq_wrap");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
